// File: rtl/arbiter_out_fifo.sv
// Elastic FWFT buffer behind arbiter_generic: absorbs the arbiter's valid/data stream,
// back-pressures it through ready_out and re-presents it downstream with valid/ready.
module arbiter_out_fifo #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AFULL = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid_in,
  input  logic [DW-1:0]            data_in,
  output logic                     ready_out,
  output logic                     valid_out,
  output logic [DW-1:0]            data_out,
  input  logic                     ready_in,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     almost_full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  // Handshake and status decode straight from the registered occupancy.
  assign ready_out   = (count != CW'(DEPTH));
  assign valid_out   = (count != CW'(0));
  assign almost_full = (count >= CW'(AFULL));
  assign data_out    = valid_out ? mem[rd_ptr] : '0;

  assign push = valid_in && ready_out;
  assign pop  = valid_out && ready_in;

  // Storage carries no reset; stale words are masked by the occupancy count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: doc/arbiter_out_fifo.md
Name: arbiter_out_fifo

Overview:
Elastic buffer placed directly downstream of arbiter_generic. It absorbs the arbiter's single valid/data output stream into a DEPTH-entry FIFO and re-presents it to the consumer with a valid/ready handshake. Its ready_out drives the arbiter's ready_in, so downstream stalls back-pressure the arbiter without losing or reordering words. It also provides an occupancy count and an almost-full flag for flow-control monitoring.

Parameters:
DW, 8, data word width in bits (matches arbiter_generic DW)
DEPTH, 8, number of FIFO entries; power of two, >= 2
AFULL, 6, almost_full threshold; 1 <= AFULL <= DEPTH
(derived) AW = log2(DEPTH); CW = AW+1

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  reset, asynchronous, active-high
valid_in  input  1  upstream word valid (from arbiter valid_out)
data_in  input  DW  upstream word (from arbiter data_out)
ready_out  output  1  FIFO can accept a word (to arbiter ready_in)
valid_out  output  1  FIFO holds at least one word for downstream
data_out  output  DW  head-of-FIFO word
ready_in  input  1  downstream accepts the head word
count  output  CW  current number of stored words, 0..DEPTH
almost_full  output  1  high when count >= AFULL

Behaviour:
- Clocking and reset: one clock, clk. rst is asynchronous and active-high. While rst is high, the outputs are held at: count=0, valid_out=0, data_out=0, ready_out=1, almost_full=0. The read pointer, write pointer and count are cleared immediately, without waiting for a clock edge. Stored contents are discarded.
- Push: occurs on a clk edge when valid_in && ready_out. data_in is written at wr_ptr, and wr_ptr advances by 1 modulo DEPTH.
- Pop: occurs on a clk edge when valid_out && ready_in. rd_ptr advances by 1 modulo DEPTH.
- Handshake outputs:
  - ready_out = (count != DEPTH); it is combinational from registered state and does not depend on ready_in.
  - valid_out = (count != 0).
- Output data: data_out = mem[rd_ptr] when valid_out=1, else 0. This is first-word-fall-through: no extra read latency.
- Latency: a word pushed on edge N is visible on valid_out/data_out after edge N. Minimum latency is 1 cycle. There is no combinational bypass from input to output.
- Count update per edge: push only gives +1; pop only gives -1; push and pop together give no change; neither gives no change.
- Full (count=DEPTH):
  - ready_out=0, so valid_in is ignored even if a pop happens in the same cycle.
  - A pop drops count to DEPTH-1, and ready_out rises on the next cycle.
- Empty (count=0): valid_out=0 and data_out=0. A pop request (ready_in=1) is ignored.
- Wrap-around: the pointers wrap modulo DEPTH. FIFO order is preserved across any number of wraps.
- Upstream hold: valid_in may be held high across stall cycles; data_in is sampled only on an accepting edge.
- Downstream stall: with valid_out=1 and ready_in=0, data_out stays stable until the pop.
- almost_full is combinational from count: high iff count >= AFULL.
- Counter width: count never exceeds DEPTH and never goes negative; CW bits are sufficient.

Test Plan:
- Reset: rst=1 asserted asynchronously between clk edges -> outputs immediately become valid_out=0, ready_out=1, count=0, data_out=0x00, almost_full=0.
- Fill (DW=8, DEPTH=8, AFULL=6), ready_in=0, push 0x00..0x07 on consecutive edges:
  - count steps 1..8; almost_full rises when count=6.
  - ready_out=0 after the 8th push; a held 9th word 0x08 is not accepted and count stays 8.
- Drain from full, ready_in=1: data_out shows 0x00..0x07 on consecutive cycles; valid_out=0 after the 8th pop; ready_out=1 after the first pop.
- Simultaneous push and pop at count=4 for 10 cycles with incrementing data -> count stays 4 and output order is strictly incrementing.
- Full plus pop with valid_in=1 at count=8 -> count=7 next cycle; the pending input word is accepted on the following edge and lands in FIFO order.
- Wrap and mid-stream reset:
  - Stream 20 words with ready_in toggling 1/0 -> order preserved across pointer wrap.
  - Assert rst at count=5 -> count=0 immediately.
  - Then push 0xA5 -> data_out=0xA5 with valid_out=1 one cycle later.
